binary_encoder: RTL and testbench



---
 rtl/binary_encoder.sv | 78 +++++++
 tb/tb_binary_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/binary_encoder.sv
// One-hot to binary index encoder with a combinational encode path and a
// registered, sticky monitor that flags non-one-hot inputs seen while enabled.
module binary_encoder #(
   parameter  int UNARY_WIDTH = 256,
   localparam int BIN_WIDTH   = $clog2(UNARY_WIDTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   input  logic [UNARY_WIDTH-1:0] i_unary,
   output logic [BIN_WIDTH-1:0]   o_bin,
   output logic                   o_valid,
   output logic                   o_error
);

   // Leaves of the one-hot detect tree are padded up to a power of two with zeros.
   localparam int TREE_LEAVES = 1 << BIN_WIDTH;

   logic [TREE_LEAVES-1:0]   unary_pad_s;
   logic [2*TREE_LEAVES-1:1] any_s;
   logic [2*TREE_LEAVES-1:1] multi_s;
   logic [BIN_WIDTH-1:0]     bin_s;
   logic                     error_d;
   logic                     error_q;

   // Heap-ordered reduction tree: node i combines children 2i and 2i+1;
   // a node is multi-hot if either child is, or both children have a bit set.
   always_comb begin
      unary_pad_s                   = '0;
      unary_pad_s[UNARY_WIDTH-1:0]  = i_unary;
      any_s                         = '0;
      multi_s                       = '0;
      for (int i = 0; i < TREE_LEAVES; i++) begin
         any_s[TREE_LEAVES+i]   = unary_pad_s[i];
         multi_s[TREE_LEAVES+i] = 1'b0;
      end
      for (int i = TREE_LEAVES - 1; i >= 1; i--) begin
         any_s[i]   = any_s[2*i] | any_s[2*i+1];
         multi_s[i] = multi_s[2*i] | multi_s[2*i+1] | (any_s[2*i] & any_s[2*i+1]);
      end
   end

   // Each set input bit contributes its own index; OR-ing them gives per-bit OR reduction.
   always_comb begin
      bin_s = '0;
      if (i_en) begin
         for (int k = 0; k < UNARY_WIDTH; k++) begin
            bin_s = bin_s | (BIN_WIDTH'(k) & {BIN_WIDTH{i_unary[k]}});
         end
      end else begin
         bin_s = '0;
      end
   end

   // Sticky error: set on an enabled multi-hot input, otherwise hold.
   always_comb begin
      error_d = error_q;
      if (i_en && multi_s[1]) begin
         error_d = 1'b1;
      end else begin
         error_d = error_q;
      end
   end

   // Error flag register with synchronous reset taking priority.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign o_bin   = bin_s;
   assign o_valid = i_en & any_s[1] & ~multi_s[1];
   assign o_error = error_q;

endmodule

// File: tb/tb_binary_encoder.sv
// Directed, table-driven bench for binary_encoder at the default width and at width 5.
module tb_binary_encoder;

   logic         clk;
   logic         rst;
   logic         en;
   logic [255:0] unary;
   logic [7:0]   bin;
   logic         valid;
   logic         error;

   logic         en5;
   logic [4:0]   unary5;
   logic [2:0]   bin5;
   logic         valid5;
   logic         error5;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic         en;
      logic [255:0] unary;
      logic [7:0]   bin;
      logic         valid;
   } vec_t;

   vec_t vecs[9];

   binary_encoder dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (en),
      .i_unary (unary),
      .o_bin   (bin),
      .o_valid (valid),
      .o_error (error)
   );

   binary_encoder #(.UNARY_WIDTH(5)) dut5 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (en5),
      .i_unary (unary5),
      .o_bin   (bin5),
      .o_valid (valid5),
      .o_error (error5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] bits2(input int a, input int b);
      logic [255:0] v;
      v    = '0;
      v[a] = 1'b1;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [255:0] hot(input int k);
      logic [255:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, hot(37),        8'd0,   1'b0};
      vecs[1] = '{1'b1, hot(37),        8'd37,  1'b1};
      vecs[2] = '{1'b1, 256'd0,         8'd0,   1'b0};
      vecs[3] = '{1'b1, bits2(1, 2),    8'd3,   1'b0};
      vecs[4] = '{1'b1, bits2(0, 255),  8'd255, 1'b0};
      vecs[5] = '{1'b1, bits2(16, 32),  8'd48,  1'b0};
      vecs[6] = '{1'b1, hot(255),       8'd255, 1'b1};
      vecs[7] = '{1'b0, ~256'd0,        8'd0,   1'b0};
      vecs[8] = '{1'b1, bits2(64, 128), 8'd192, 1'b0};

      rst    = 1'b1;
      en     = 1'b0;
      unary  = '0;
      en5    = 1'b0;
      unary5 = 5'd0;

      // Reset state
      @(posedge clk); #1;
      chk("reset_error", int'(error), 0);
      chk("reset_error5", int'(error5), 0);
      @(negedge clk);
      rst = 1'b0;

      // Exhaustive one-hot sweep, one value per cycle
      en = 1'b1;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         unary = hot(k);
         #1;
         chk("sweep_bin", int'(bin), k);
         chk("sweep_sel", int'(unary[bin]), 1);
         chk("sweep_valid", int'(valid), 1);
      end
      @(posedge clk); #1;
      chk("sweep_error", int'(error), 0);

      // Disable, then enable with no clock edge in between
      @(negedge clk);
      en    = 1'b0;
      unary = hot(37);
      #1;
      chk("dis_bin", int'(bin), 0);
      chk("dis_valid", int'(valid), 0);
      en = 1'b1;
      #1;
      chk("en_bin", int'(bin), 37);
      chk("en_valid", int'(valid), 1);

      // All-zero idle for three cycles
      @(negedge clk);
      unary = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("zero_bin", int'(bin), 0);
         chk("zero_valid", int'(valid), 0);
         @(posedge clk); #1;
         chk("zero_error", int'(error), 0);
      end

      // Multi-hot sets the sticky error at the next edge
      @(negedge clk);
      unary = bits2(1, 2);
      #1;
      chk("multi_bin", int'(bin), 3);
      chk("multi_valid", int'(valid), 0);
      chk("multi_error_pre", int'(error), 0);
      @(posedge clk); #1;
      chk("multi_error_set", int'(error), 1);
      @(negedge clk);
      unary = hot(5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("multi_error_hold", int'(error), 1);
      chk("legal_bin", int'(bin), 5);

      // Reset clears the flag
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_clear", int'(error), 0);

      // Reset wins over a simultaneous illegal input; encode path still tracks
      @(negedge clk);
      unary = bits2(1, 2);
      @(posedge clk); #1;
      chk("rst_prio_error", int'(error), 0);
      chk("rst_prio_bin", int'(bin), 3);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_release_error", int'(error), 1);

      // Disabled monitor does not update on multi-hot input
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("dis_monitor_error", int'(error), 0);

      // Table of directed vectors
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         en    = vecs[i].en;
         unary = vecs[i].unary;
         #1;
         chk($sformatf("vec%0d_bin", i), int'(bin), int'(vecs[i].bin));
         chk($sformatf("vec%0d_valid", i), int'(valid), int'(vecs[i].valid));
      end

      // Narrow instance: width 5, 3-bit index
      en5 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         unary5 = 5'd1 << k;
         #1;
         chk("w5_bin", int'(bin5), k);
         chk("w5_valid", int'(valid5), 1);
      end
      @(posedge clk); #1;
      chk("w5_error_clean", int'(error5), 0);
      @(negedge clk);
      unary5 = 5'b11000;
      #1;
      chk("w5_multi_bin", int'(bin5), 7);
      chk("w5_multi_valid", int'(valid5), 0);
      @(posedge clk); #1;
      chk("w5_multi_error", int'(error5), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
